// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and types for the fetch stage
package cpu_pkg;

   localparam int unsigned INSTRUCT_MEM_SIZE = 1024;
   localparam logic [31:0] NOP_INSTR         = 32'd0;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - next-PC selection and fetch address legality check
module pc_next
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_SIZE = INSTRUCT_MEM_SIZE
) (
   input  logic [63:0] pc,
   input  logic        br_taken,
   input  logic [63:0] br_target,
   input  logic        stall,
   input  logic        faulted,
   output logic [63:0] pc_nxt,
   output logic        pc_legal
);

   // pc < MEM_SIZE-3 avoids the 64-bit wrap that pc+3 could hit near the top
   localparam logic [63:0] PC_LIMIT = 64'(MEM_SIZE) - 64'd3;

   assign pc_legal = (pc[1:0] == 2'b00) && (pc < PC_LIMIT);

   always_comb begin
      pc_nxt = pc;
      if (!faulted) begin
         if (br_taken) begin
            pc_nxt = br_target;
         end else if (!stall && pc_legal) begin
            pc_nxt = pc + 64'd4;
         end
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, ROM address, IF/ID register
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int unsigned  MEM_SIZE = INSTRUCT_MEM_SIZE,
   parameter logic [63:0]  RESET_PC = 64'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        flush,
   input  logic        br_taken,
   input  logic [63:0] br_target,
   output logic [63:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_valid,
   output logic        fetch_fault,
   output logic [31:0] fetch_count
);

   fetch_state_t state_q, state_d;
   logic [63:0]  pc_q, pc_d;
   logic [63:0]  if_pc_q, if_pc_d;
   logic [31:0]  if_instr_q, if_instr_d;
   logic         if_valid_q, if_valid_d;
   logic         fault_q, fault_d;
   logic [31:0]  count_q, count_d;
   logic         pc_legal;

   pc_next #(.MEM_SIZE(MEM_SIZE)) u_pc_next (
      .pc        (pc_q),
      .br_taken  (br_taken),
      .br_target (br_target),
      .stall     (stall),
      .faulted   (state_q == FAULT),
      .pc_nxt    (pc_d),
      .pc_legal  (pc_legal)
   );

   always_comb begin
      state_d    = state_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if_valid_d = if_valid_q;
      fault_d    = fault_q;
      count_d    = count_q;
      if (state_q == FAULT) begin
         if_valid_d = 1'b0;
         fault_d    = 1'b1;
      end else if (br_taken) begin
         // wrong-path squash; the old PC is never checked
         if_valid_d = 1'b0;
      end else if (stall) begin
         if (flush) begin
            if_valid_d = 1'b0;
         end
      end else if (!pc_legal) begin
         state_d    = FAULT;
         fault_d    = 1'b1;
         if_valid_d = 1'b0;
      end else begin
         if_pc_d    = pc_q;
         if_instr_d = imem_instr;
         if_valid_d = ~flush;
         if (!flush) begin
            count_d = count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         if_pc_q    <= 64'd0;
         if_instr_q <= NOP_INSTR;
         if_valid_q <= 1'b0;
         fault_q    <= 1'b0;
         count_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         if_valid_q <= if_valid_d;
         fault_q    <= fault_d;
         count_q    <= count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign if_pc       = if_pc_q;
   assign if_instr    = if_instr_q;
   assign if_valid    = if_valid_q;
   assign fetch_fault = fault_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        br_taken = 1'b0;
   logic [63:0] br_target = 64'd0;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        fetch_fault;
   logic [31:0] fetch_count;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] rom [0:255];

   always #5 clk = ~clk;

   assign imem_instr = (imem_addr < 64'd1024) ? rom[imem_addr[9:2]] : 32'hDEAD_BEEF;

   instr_fetch dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .stall       (stall),
      .flush       (flush),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .if_valid    (if_valid),
      .fetch_fault (fetch_fault),
      .fetch_count (fetch_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      br_taken = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 32'hE3A0_0000 + 32'(i);

      // reset state
      do_reset();
      check("rst_addr",  imem_addr, 64'd0);
      check("rst_ifpc",  if_pc, 64'd0);
      check("rst_instr", {32'd0, if_instr}, 64'd0);
      check("rst_valid", {63'd0, if_valid}, 64'd0);
      check("rst_fault", {63'd0, fetch_fault}, 64'd0);
      check("rst_count", {32'd0, fetch_count}, 64'd0);

      // free-running fetch
      step();
      check("run0_pc",    if_pc, 64'd0);
      check("run0_instr", {32'd0, if_instr}, 64'hE3A0_0000);
      check("run0_valid", {63'd0, if_valid}, 64'd1);
      step();
      check("run1_pc",    if_pc, 64'd4);
      check("run1_instr", {32'd0, if_instr}, 64'hE3A0_0001);
      step();
      check("run2_pc",    if_pc, 64'd8);
      step();
      check("run3_pc",    if_pc, 64'd12);
      check("run3_instr", {32'd0, if_instr}, 64'hE3A0_0003);
      check("run3_count", {32'd0, fetch_count}, 64'd4);
      check("run3_addr",  imem_addr, 64'd16);

      // stall at PC=8
      do_reset();
      step();
      step();
      check("pre_stall_addr", imem_addr, 64'd8);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("stall_addr",  imem_addr, 64'd8);
         check("stall_ifpc",  if_pc, 64'd4);
         check("stall_count", {32'd0, fetch_count}, 64'd2);
         check("stall_valid", {63'd0, if_valid}, 64'd1);
      end
      stall = 1'b0;
      step();
      check("unstall_ifpc",  if_pc, 64'd8);
      check("unstall_count", {32'd0, fetch_count}, 64'd3);

      // flush without stall at PC=12
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_ifpc",  if_pc, 64'd12);
      check("flush_valid", {63'd0, if_valid}, 64'd0);
      check("flush_count", {32'd0, fetch_count}, 64'd3);
      check("flush_addr",  imem_addr, 64'd16);

      // branch overrides stall
      stall     = 1'b1;
      br_taken  = 1'b1;
      br_target = 64'h40;
      step();
      stall    = 1'b0;
      br_taken = 1'b0;
      check("br_addr",  imem_addr, 64'h40);
      check("br_valid", {63'd0, if_valid}, 64'd0);
      step();
      check("br_ifpc",  if_pc, 64'h40);
      check("br_instr", {32'd0, if_instr}, 64'hE3A0_0010);
      check("br_valid2", {63'd0, if_valid}, 64'd1);
      check("br_count", {32'd0, fetch_count}, 64'd4);

      // last legal word then run off the end
      do_reset();
      br_taken  = 1'b1;
      br_target = 64'h3FC;
      step();
      br_taken = 1'b0;
      step();
      check("edge_ifpc",  if_pc, 64'h3FC);
      check("edge_instr", {32'd0, if_instr}, 64'hE3A0_00FF);
      check("edge_valid", {63'd0, if_valid}, 64'd1);
      check("edge_fault", {63'd0, fetch_fault}, 64'd0);
      step();
      check("end_fault", {63'd0, fetch_fault}, 64'd1);
      check("end_valid", {63'd0, if_valid}, 64'd0);
      check("end_addr",  imem_addr, 64'h400);

      // misaligned and out-of-range redirect targets
      for (int r = 0; r < 2; r++) begin
         logic [63:0] tgt;
         tgt = (r == 0) ? 64'h3FE : 64'h400;
         do_reset();
         step();
         br_taken  = 1'b1;
         br_target = tgt;
         step();
         br_taken = 1'b0;
         check("redir_nofault", {63'd0, fetch_fault}, 64'd0);
         check("redir_addr",    imem_addr, tgt);
         step();
         check("redir_fault", {63'd0, fetch_fault}, 64'd1);
         check("redir_valid", {63'd0, if_valid}, 64'd0);
         check("redir_ifpc",  if_pc, 64'd0);
         br_taken  = 1'b1;
         br_target = 64'h0;
         stall     = 1'b1;
         step();
         step();
         br_taken = 1'b0;
         stall    = 1'b0;
         check("fault_hold_addr",  imem_addr, tgt);
         check("fault_hold_fault", {63'd0, fetch_fault}, 64'd1);
         check("fault_hold_count", {32'd0, fetch_count}, 64'd1);
      end

      // asynchronous reset mid-stream
      do_reset();
      for (int k = 0; k < 8; k++) step();
      check("mid_addr", imem_addr, 64'h20);
      reset_n = 1'b0;
      #2;
      check("async_addr",  imem_addr, 64'd0);
      check("async_ifpc",  if_pc, 64'd0);
      check("async_valid", {63'd0, if_valid}, 64'd0);
      check("async_count", {32'd0, fetch_count}, 64'd0);
      reset_n = 1'b1;
      step();
      check("restart_ifpc",  if_pc, 64'd0);
      check("restart_valid", {63'd0, if_valid}, 64'd1);
      check("restart_count", {32'd0, fetch_count}, 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
